// File: rtl/rst_code_sched.sv
// Round-robin scheduler that frames requester command codes onto the serial m_rst line, filling gaps with idle words.
// Define RST_CODE_SCHED_PERIODIC_EN to add an internal periodic SYNC_CODE source with top priority.
module rst_code_sched #(
  parameter int                   NREQ        = 4,
  parameter int                   CODE_BITS   = 4,
  parameter logic [CODE_BITS-1:0] IDLE_CODE   = CODE_BITS'(4'b1010),
  parameter logic [CODE_BITS-1:0] SYNC_CODE   = CODE_BITS'(4'b1110),
  parameter int                   SYNC_PERIOD = 100_000_000
) (
  input  logic                      clk_100,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*CODE_BITS-1:0] code,
  output logic [NREQ-1:0]           ack,
  output logic                      m_rst,
  output logic                      frame_start,
  output logic                      grant_valid,
  output logic                      sync_sent
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(CODE_BITS);

  logic [CODE_BITS-1:0] shift_reg;
  logic [CNT_W-1:0]     bit_cnt;
  logic [PTR_W-1:0]     ptr;
  logic                 boundary;
  logic                 sync_now;

  logic                 req_any;
  logic [PTR_W-1:0]     ptr_nxt;
  logic [NREQ-1:0]      ack_set;
  logic [CODE_BITS-1:0] win_code;

  function automatic int rr_index(input logic [PTR_W-1:0] base, input int k);
    return (int'(base) + k) % NREQ;
  endfunction

  assign boundary = (bit_cnt == CNT_W'(CODE_BITS - 1));
  assign m_rst    = shift_reg[CODE_BITS-1];

  // Search order starts at ptr; the outer loop walks priority, the inner one maps it onto a constant requester index.
  always_comb begin
    req_any  = 1'b0;
    ptr_nxt  = ptr;
    ack_set  = '0;
    win_code = IDLE_CODE;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!req_any && req[j] && (rr_index(ptr, k) == j)) begin
          req_any    = 1'b1;
          ptr_nxt    = PTR_W'((j + 1) % NREQ);
          ack_set    = '0;
          ack_set[j] = 1'b1;
          win_code   = code[j*CODE_BITS +: CODE_BITS];
        end
      end
    end
  end

`ifdef RST_CODE_SCHED_PERIODIC_EN
  localparam int TMR_W = $clog2(SYNC_PERIOD);

  logic [TMR_W-1:0] timer;
  logic             pending;
  logic             wrap;

  assign wrap     = (timer == TMR_W'(SYNC_PERIOD - 1));
  // A wrap landing on the boundary cycle is serviced right there, without passing through pending.
  assign sync_now = pending | wrap;

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      timer   <= '0;
      pending <= 1'b0;
    end else begin
      timer <= wrap ? '0 : timer + 1'b1;
      if (boundary && sync_now) pending <= 1'b0;
      else if (wrap)            pending <= 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign sync_now   = 1'b0;
  assign unused_cfg = ^SYNC_CODE ^ (SYNC_PERIOD == 0);
`endif

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      shift_reg   <= IDLE_CODE;
      bit_cnt     <= '0;
      ptr         <= '0;
      ack         <= '0;
      frame_start <= 1'b0;
      grant_valid <= 1'b0;
      sync_sent   <= 1'b0;
    end else if (!boundary) begin
      shift_reg   <= {shift_reg[CODE_BITS-2:0], 1'b0};
      bit_cnt     <= bit_cnt + 1'b1;
      ack         <= '0;
      frame_start <= 1'b0;
      sync_sent   <= 1'b0;
    end else begin
      // Word boundary: pick the next word; its MSB and the strobes appear together next cycle.
      bit_cnt     <= '0;
      frame_start <= 1'b1;
      if (sync_now) begin
        shift_reg   <= SYNC_CODE;
        ack         <= '0;
        grant_valid <= 1'b1;
        sync_sent   <= 1'b1;
      end else if (req_any) begin
        shift_reg   <= win_code;
        ack         <= ack_set;
        ptr         <= ptr_nxt;
        grant_valid <= 1'b1;
        sync_sent   <= 1'b0;
      end else begin
        shift_reg   <= IDLE_CODE;
        ack         <= '0;
        grant_valid <= 1'b0;
        sync_sent   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rst_code_sched.sv
// Directed testbench for rst_code_sched: idle framing, single grant, withdrawal, round-robin, async reset, periodic sync.
module tb_rst_code_sched;

  logic        clk_100 = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] code;
  logic [3:0]  ack;
  logic        m_rst;
  logic        frame_start;
  logic        grant_valid;
  logic        sync_sent;

  int errs   = 0;
  int checks = 0;

`ifdef RST_CODE_SCHED_PERIODIC_EN
  localparam bit PERIODIC = 1'b1;
`else
  localparam bit PERIODIC = 1'b0;
`endif

  rst_code_sched #(
    .NREQ(4), .CODE_BITS(4), .IDLE_CODE(4'b1010), .SYNC_CODE(4'b1110), .SYNC_PERIOD(40)
  ) dut (
    .clk_100(clk_100), .rst(rst), .req(req), .code(code), .ack(ack),
    .m_rst(m_rst), .frame_start(frame_start), .grant_valid(grant_valid), .sync_sent(sync_sent)
  );

  always #5 clk_100 = ~clk_100;

  task automatic tick;
    @(negedge clk_100);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic wait_frame;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      tick;
      if (frame_start === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errs++;
      $display("FAIL wait_frame got=no frame_start want=frame_start within 16 cycles");
    end
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    req  = 4'b0000;
    code = 16'h0000;
    tick;
    tick;
    checks++;
    if (m_rst !== 1'b1) begin errs++; $display("FAIL reset_m_rst got=%b want=1", m_rst); end
    checks++;
    if (frame_start !== 1'b0) begin errs++; $display("FAIL reset_frame_start got=%b want=0", frame_start); end
    checks++;
    if (ack !== 4'b0000) begin errs++; $display("FAIL reset_ack got=%b want=0000", ack); end
    checks++;
    if (grant_valid !== 1'b0) begin errs++; $display("FAIL reset_grant_valid got=%b want=0", grant_valid); end
    checks++;
    if (sync_sent !== 1'b0) begin errs++; $display("FAIL reset_sync_sent got=%b want=0", sync_sent); end
  endtask

  task automatic test_idle;
    logic em, ef;
    req = 4'b0000;
    do_reset;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) tick;
      em = (k % 2 == 0);
      ef = (k % 4 == 0) && (k != 0);
      checks++;
      if (m_rst !== em) begin errs++; $display("FAIL idle_m_rst k=%0d got=%b want=%b", k, m_rst, em); end
      checks++;
      if (frame_start !== ef) begin errs++; $display("FAIL idle_frame_start k=%0d got=%b want=%b", k, frame_start, ef); end
      checks++;
      if (ack !== 4'b0000 || grant_valid !== 1'b0) begin
        errs++;
        $display("FAIL idle_ack_gv k=%0d got=%b/%b want=0000/0", k, ack, grant_valid);
      end
    end
  endtask

  task automatic test_single;
    logic [7:0] pat;
    logic [3:0] ea;
    logic       em, ef, eg;
    pat = 8'b1100_1010;
    req = 4'b0000;
    do_reset;
    wait_frame;
    req  = 4'b0001;
    code = 16'h000C;
    for (int c = 1; c <= 11; c++) begin
      tick;
      ea = (c == 4) ? 4'b0001 : 4'b0000;
      ef = (c % 4 == 0);
      checks++;
      if (ack !== ea) begin errs++; $display("FAIL single_ack c=%0d got=%b want=%b", c, ack, ea); end
      checks++;
      if (frame_start !== ef) begin errs++; $display("FAIL single_frame_start c=%0d got=%b want=%b", c, frame_start, ef); end
      if (c == 4) req = 4'b0000;
      if (c >= 4) begin
        em = pat[3'(11 - c)];
        eg = (c <= 7);
        checks++;
        if (m_rst !== em) begin errs++; $display("FAIL single_m_rst c=%0d got=%b want=%b", c, m_rst, em); end
        checks++;
        if (grant_valid !== eg) begin errs++; $display("FAIL single_grant_valid c=%0d got=%b want=%b", c, grant_valid, eg); end
      end
    end
  endtask

  task automatic test_withdraw;
    req = 4'b0000;
    do_reset;
    wait_frame;
    tick;
    req  = 4'b0010;
    code = 16'h0030;
    tick;
    req = 4'b0000;
    tick;
    tick;
    checks++;
    if (ack !== 4'b0000 || grant_valid !== 1'b0 || m_rst !== 1'b1 || frame_start !== 1'b1) begin
      errs++;
      $display("FAIL withdraw_idle got=ack %b gv %b m %b fs %b want=ack 0000 gv 0 m 1 fs 1",
               ack, grant_valid, m_rst, frame_start);
    end
    tick;
    req = 4'b0010;
    tick;
    checks++;
    if (ack !== 4'b0000) begin errs++; $display("FAIL late_req_early_ack got=%b want=0000", ack); end
    tick;
    tick;
    checks++;
    if (ack !== 4'b0010 || m_rst !== 1'b0 || grant_valid !== 1'b1) begin
      errs++;
      $display("FAIL late_req_grant got=ack %b m %b gv %b want=ack 0010 m 0 gv 1", ack, m_rst, grant_valid);
    end
    req = 4'b0000;
  endtask

  task automatic test_round_robin;
    logic [3:0] cw, ea;
    int         j, b;
    req  = 4'b1111;
    code = 16'h8421;
    do_reset;
    for (int n = 1; n <= 27; n++) begin
      tick;
      if (n >= 4) begin
        j  = (n - 4) / 4;
        b  = (n - 4) % 4;
        cw = 4'b0001 << (j % 4);
        ea = (b == 0) ? cw : 4'b0000;
        checks++;
        if (ack !== ea) begin errs++; $display("FAIL rr_ack word=%0d bit=%0d got=%b want=%b", j, b, ack, ea); end
        checks++;
        if (m_rst !== cw[2'(3 - b)]) begin
          errs++;
          $display("FAIL rr_m_rst word=%0d bit=%0d got=%b want=%b", j, b, m_rst, cw[2'(3 - b)]);
        end
        checks++;
        if (grant_valid !== 1'b1) begin errs++; $display("FAIL rr_grant_valid word=%0d bit=%0d got=%b want=1", j, b, grant_valid); end
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_idle_word;
    req = 4'b0000;
    do_reset;
    wait_frame;
    req  = 4'b0100;
    code = 16'h0A00;
    tick; tick; tick; tick;
    checks++;
    if (ack !== 4'b0100 || grant_valid !== 1'b1 || m_rst !== 1'b1) begin
      errs++;
      $display("FAIL idle_word_grant got=ack %b gv %b m %b want=ack 0100 gv 1 m 1", ack, grant_valid, m_rst);
    end
    req = 4'b0000;
    tick;
    checks++;
    if (grant_valid !== 1'b1 || m_rst !== 1'b0) begin
      errs++;
      $display("FAIL idle_word_bit1 got=gv %b m %b want=gv 1 m 0", grant_valid, m_rst);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] pat;
    logic       em;
    pat = 8'b1010_0110;
    req = 4'b0000;
    do_reset;
    wait_frame;
    req  = 4'b0100;
    code = 16'h0C00;
    tick; tick; tick; tick;
    checks++;
    if (ack !== 4'b0100) begin errs++; $display("FAIL mid_pre_ack got=%b want=0100", ack); end
    tick;
    tick;
    checks++;
    if (m_rst !== 1'b0) begin errs++; $display("FAIL mid_bit2 got=%b want=0", m_rst); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (m_rst !== 1'b1 || ack !== 4'b0000 || grant_valid !== 1'b0 || frame_start !== 1'b0) begin
      errs++;
      $display("FAIL mid_async_reset got=m %b ack %b gv %b fs %b want=m 1 ack 0000 gv 0 fs 0",
               m_rst, ack, grant_valid, frame_start);
    end
    req  = 4'b1001;
    code = 16'h3006;
    tick;
    rst = 1'b0;
    for (int n = 0; n <= 7; n++) begin
      if (n > 0) tick;
      em = pat[3'(7 - n)];
      checks++;
      if (m_rst !== em) begin errs++; $display("FAIL mid_after_m_rst n=%0d got=%b want=%b", n, m_rst, em); end
      if (n < 4) begin
        checks++;
        if (ack !== 4'b0000 || grant_valid !== 1'b0 || frame_start !== 1'b0) begin
          errs++;
          $display("FAIL mid_after_idle n=%0d got=ack %b gv %b fs %b want=ack 0000 gv 0 fs 0",
                   n, ack, grant_valid, frame_start);
        end
      end
      if (n == 4) begin
        checks++;
        if (ack !== 4'b0001 || grant_valid !== 1'b1 || frame_start !== 1'b1) begin
          errs++;
          $display("FAIL mid_after_ptr got=ack %b gv %b fs %b want=ack 0001 gv 1 fs 1",
                   ack, grant_valid, frame_start);
        end
        req = 4'b0000;
      end
    end
  endtask

  task automatic test_sync;
    logic [3:0] w, ea;
    logic       issync, es;
    int         j, b;
    int         nsync;
    nsync = 0;
    req   = 4'b0010;
    code  = 16'h0030;
    do_reset;
    for (int n = 1; n <= 123; n++) begin
      tick;
      j = n / 4;
      b = n % 4;
      if (j >= 1) begin
        issync = PERIODIC && (j % 10 == 0);
        w      = issync ? 4'b1110 : 4'b0011;
        ea     = (b == 0 && !issync) ? 4'b0010 : 4'b0000;
        es     = (b == 0) && issync;
        if (sync_sent === 1'b1) nsync++;
        checks++;
        if (m_rst !== w[2'(3 - b)]) begin
          errs++;
          $display("FAIL sync_m_rst word=%0d bit=%0d got=%b want=%b", j, b, m_rst, w[2'(3 - b)]);
        end
        checks++;
        if (ack !== ea || sync_sent !== es || grant_valid !== 1'b1 || frame_start !== (b == 0)) begin
          errs++;
          $display("FAIL sync_ctl word=%0d bit=%0d got=ack %b ss %b gv %b fs %b want=ack %b ss %b gv 1 fs %b",
                   j, b, ack, sync_sent, grant_valid, frame_start, ea, es, (b == 0));
        end
      end
    end
    checks++;
    if (nsync != (PERIODIC ? 3 : 0)) begin
      errs++;
      $display("FAIL sync_count got=%0d want=%0d", nsync, (PERIODIC ? 3 : 0));
    end
    req = 4'b0000;
  endtask

  initial begin
    test_reset;
    test_idle;
    test_single;
    test_withdraw;
    test_round_robin;
    test_idle_word;
    test_reset_mid;
    test_sync;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
